// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared tri-state data bus. It drives one-hot
// driver enables and inserts a two-cycle undriven turnaround between owners.
module bus_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] drv_en,
  output logic               bus_busy,
  output logic [ID_W-1:0]    owner_id
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ARB = 2'd0,
    OWN = 2'd1,
    GAP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    owner_id_q, owner_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic               bus_busy_q, bus_busy_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W:0]      scan_idx;
  logic [ID_W:0]      next_ptr;
  logic               others_waiting;
  logic               hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      grant_q    <= '0;
      owner_id_q <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      bus_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_id_q <= owner_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      bus_busy_q <= bus_busy_d;
    end
  end

  // Scan from rr_ptr upward with wrap; the first set request wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
      if (scan_idx >= (ID_W + 1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
      end
      if (!found && req[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
    next_ptr = {1'b0, winner} + (ID_W + 1)'(1);
    if (next_ptr >= (ID_W + 1)'(NUM_REQ)) begin
      next_ptr = '0;
    end
  end

  assign others_waiting = |(req & ~grant_q);
  assign hold_full      = (hold_cnt_q == HC_W'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_id_d = owner_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB: begin
        grant_d = '0;
        if (found) begin
          grant_d    = NUM_REQ'(1) << winner;
          owner_id_d = winner;
          hold_cnt_d = HC_W'(1);
          rr_ptr_d   = next_ptr[ID_W-1:0];
          state_d    = OWN;
        end
      end
      OWN: begin
        // Preempt only when someone else is waiting; a lone owner keeps the bus.
        if (!req[owner_id_q] || (hold_full && others_waiting)) begin
          grant_d = '0;
          state_d = GAP;
        end else if (!hold_full) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = ARB;
      end
      default: begin
        grant_d = '0;
        state_d = ARB;
      end
    endcase
    bus_busy_d = |grant_d;
  end

  assign grant    = grant_q;
  assign drv_en   = grant_q;
  assign bus_busy = bus_busy_q;
  assign owner_id = owner_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter ownership sequencing, turnaround,
// preemption and fairness, with a modelled 8-bit shared bus.
module tb_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 4;
  localparam int BOUND    = (NUM_REQ - 1) * (MAX_HOLD + 2) + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] drv_en;
  logic       bus_busy;
  logic [1:0] owner_id;

  int checks = 0;
  int errors = 0;

  logic [7:0] data_in [NUM_REQ];
  logic [7:0] bus_val;
  int         n_drv;
  int         wait_cnt [NUM_REQ];
  int         max_wait;

  bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .drv_en   (drv_en),
    .bus_busy (bus_busy),
    .owner_id (owner_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] o);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".drv_en"}, 32'(drv_en), 32'(g));
    chk({tag, ".bus_busy"}, 32'(bus_busy), 32'(|g));
    chk({tag, ".owner_id"}, 32'(owner_id), 32'(o));
  endtask

  // Resolve the modelled bus: count active drivers and take the enabled data.
  task automatic resolve_bus();
    bus_val = '0;
    n_drv   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (drv_en[i]) begin
        bus_val = data_in[i];
        n_drv++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_in[i]  = '0;
      wait_cnt[i] = 0;
    end
    tick();
    tick();
    check_out("reset", 4'b0000, 2'd0);

    // Single requester, then owner swap on the same edge.
    rst = 1'b0;
    req = 4'b0100;
    tick(); check_out("single_grant", 4'b0100, 2'd2);
    tick(); check_out("single_hold", 4'b0100, 2'd2);
    req = 4'b0010;
    tick(); check_out("single_rel", 4'b0000, 2'd2);
    tick(); check_out("single_gap", 4'b0000, 2'd2);
    tick(); check_out("next_grant", 4'b0010, 2'd1);
    req = 4'b0000;
    tick(); check_out("idle_rel", 4'b0000, 2'd1);
    tick(); check_out("idle_gap", 4'b0000, 2'd1);
    tick(); check_out("idle_arb", 4'b0000, 2'd1);

    // Full contention: each owner exactly MAX_HOLD cycles, two idle cycles between.
    rst = 1'b1;
    req = 4'b1111;
    tick(); check_out("rr_reset", 4'b0000, 2'd0);
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick(); check_out("rr_own", 4'b0001 << (g % 4), 2'(g % 4));
      end
      if (g < 4) begin
        for (int c = 0; c < 2; c++) begin
          tick(); check_out("rr_gap", 4'b0000, 2'(g % 4));
        end
      end
    end

    // Uncontended owner keeps the bus; its saturated count preempts at once later.
    rst = 1'b1;
    req = 4'b0000;
    tick(); check_out("unc_reset", 4'b0000, 2'd0);
    rst = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick(); check_out("unc_own", 4'b0001, 2'd0);
    end
    req = 4'b0011;
    tick(); check_out("sat_preempt", 4'b0000, 2'd0);
    tick(); check_out("sat_gap", 4'b0000, 2'd0);
    tick(); check_out("sat_grant", 4'b0010, 2'd1);

    // Mid-ownership reset restores the pointer to source 0.
    req = 4'b0100;
    tick(); check_out("to2_rel", 4'b0000, 2'd1);
    tick(); check_out("to2_gap", 4'b0000, 2'd1);
    tick(); check_out("to2_grant", 4'b0100, 2'd2);
    rst = 1'b1;
    req = 4'b1111;
    tick(); check_out("mid_rst", 4'b0000, 2'd0);
    rst = 1'b0;
    tick(); check_out("post_rst", 4'b0001, 2'd0);

    // Randomized traffic on the modelled bus: exclusivity, data routing, fairness.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    max_wait = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      resolve_bus();
      chk("onehot0", 32'($countones(grant) <= 1), 32'd1);
      chk("drv_eq_grant", 32'(drv_en), 32'(grant));
      chk("busy_drivers", 32'(n_drv), bus_busy ? 32'd1 : 32'd0);
      if (bus_busy) begin
        chk("owner_onehot", 32'(grant), 32'(4'b0001 << owner_id));
        chk("bus_data", 32'(bus_val), 32'(data_in[owner_id]));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !grant[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      chk("fairness", 32'(max_wait <= BOUND), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        data_in[i] = 8'($urandom_range(0, 255));
        if (grant[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
